// File: rtl/nano_int_unit.sv
// nano_int_unit: N_CH-channel external interrupt unit with input synchronisers,
// per-channel edge selection, software-set pending bits and a lowest-index-wins
// priority encoder. Sits on the Nano CPU I/O bus at ADD_BASE..ADD_BASE+5.

// Per-channel slice: synchroniser, edge detector and pending bit.
module nano_int_ch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic NRST,
  input  logic eint,
  input  logic pol,
  input  logic both,
  input  logic primed,
  input  logic clr,
  input  logic sw,
  output logic pend
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   s, rise, fall, evt;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser chain plus one extra delayed copy of its output for edge compare.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], eint};
      prev <= s;
    end
  end

  // Edge selection; nothing fires until the synchroniser has been flushed after reset.
  always_comb begin
    rise = s & ~prev;
    fall = ~s & prev;
    evt  = 1'b0;
    if (primed) evt = both ? (rise | fall) : (pol ? fall : rise);
  end

  // Pending bit: hardware or software set wins over a simultaneous W1C.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) pend <= 1'b0;
    else       pend <= (pend & ~clr) | evt | sw;
  end
endmodule

module nano_int_unit #(
  parameter int         N_CH        = 3,
  parameter logic [7:0] ADD_BASE    = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic [N_CH-1:0] EINT,
  input  logic [7:0]      io_add,
  input  logic [7:0]      io_wdata,
  output logic [7:0]      io_rdata,
  input  logic            io_we,
  output logic [N_CH-1:0] irq,
  output logic            irq_any,
  output logic [2:0]      irq_id
);
  localparam logic [2:0] PRIME = 3'(SYNC_STAGES + 1);

  logic [2:0]      prime_cnt;
  logic            primed;
  logic [8:0]      off9;
  logic            hit;
  logic [2:0]      off;
  logic            wr_en, wr_pend, wr_pol, wr_both, wr_set;
  logic [N_CH-1:0] en, pol, both, pend;

  // 9-bit subtraction so addresses below ADD_BASE wrap far out of range.
  assign off9    = {1'b0, io_add} - {1'b0, ADD_BASE};
  assign hit     = off9 < 9'd6;
  assign off     = off9[2:0];
  assign wr_en   = io_we & hit & (off == 3'd0);
  assign wr_pend = io_we & hit & (off == 3'd1);
  assign wr_pol  = io_we & hit & (off == 3'd2);
  assign wr_both = io_we & hit & (off == 3'd3);
  assign wr_set  = io_we & hit & (off == 3'd5);
  assign primed  = (prime_cnt == PRIME);

  if (N_CH < 8) begin : g_unused
    logic unused_wd;
    assign unused_wd = &io_wdata[7:N_CH];
  end

  // Priming counter: counts edges since reset release, then saturates.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)       prime_cnt <= 3'd0;
    else if (!primed) prime_cnt <= prime_cnt + 3'd1;
  end

  // Plain R/W control registers.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      en   <= '0;
      pol  <= '0;
      both <= '0;
    end else begin
      if (wr_en)   en   <= io_wdata[N_CH-1:0];
      if (wr_pol)  pol  <= io_wdata[N_CH-1:0];
      if (wr_both) both <= io_wdata[N_CH-1:0];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    nano_int_ch #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .CLK    (CLK),
      .NRST   (NRST),
      .eint   (EINT[g]),
      .pol    (pol[g]),
      .both   (both[g]),
      .primed (primed),
      .clr    (wr_pend & io_wdata[g]),
      .sw     (wr_set & io_wdata[g]),
      .pend   (pend[g])
    );
  end

  assign irq     = pend & en;
  assign irq_any = |irq;

  // Priority encode: scan from the top so the lowest active index is left standing.
  always_comb begin
    irq_id = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) if (irq[i]) irq_id = 3'(i);
  end

  // Register read mux; unused upper bits and undecoded addresses read zero.
  always_comb begin
    io_rdata = 8'h00;
    if (hit) begin
      case (off)
        3'd0:    io_rdata[N_CH-1:0] = en;
        3'd1:    io_rdata[N_CH-1:0] = pend;
        3'd2:    io_rdata[N_CH-1:0] = pol;
        3'd3:    io_rdata[N_CH-1:0] = both;
        3'd4:    io_rdata = {irq_any, 4'b0000, irq_id};
        default: io_rdata = 8'h00;
      endcase
    end
  end
endmodule

// File: doc/nano_int_unit.md
Name: nano_int_unit

Overview:
- Parametrised external-interrupt unit for the Nano CPU.
- Replaces the fixed three-channel arrangement of separate edge detectors plus interrupt controller with a single block that has:
  - N_CH channels;
  - input synchronisers;
  - per-channel edge polarity selection;
  - software-set pending bits;
  - a priority encoder.
- Sits on the CPU I/O bus (io_add/io_o/io_i/io_we) and drives the CPU interrupt request lines directly.

Parameters:
N_CH, 3, number of interrupt channels (1..8)
ADD_BASE, 8'h00, I/O address of register offset 0; the block decodes ADD_BASE..ADD_BASE+5
SYNC_STAGES, 2, synchroniser flip-flops per EINT input (2..4)

Ports:
CLK  input  1  system clock, rising edge
NRST  input  1  asynchronous active-low reset
EINT  input  N_CH  asynchronous external interrupt inputs
io_add  input  8  CPU I/O address
io_wdata  input  8  CPU write data (CPU io_o)
io_rdata  output  8  read data to CPU (CPU io_i)
io_we  input  1  CPU I/O write strobe
irq  output  N_CH  per-channel request, equals PEND & EN
irq_any  output  1  OR of irq
irq_id  output  3  index of highest-priority active request; 0 when none

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous and active-low on NRST, and clears all flops.
- Reset values: EN=0, PEND=0, POL=0, BOTH=0, synchronisers=0, prev-sample=0, prime counter=0. Hence irq=0, irq_any=0, irq_id=0.
- Registers (offset from ADD_BASE; bits >= N_CH read 0 and ignore writes):
  - 0 EN (R/W): enable mask.
  - 1 PEND (R, write-1-to-clear).
  - 2 POL (R/W): 0 = rising edge, 1 = falling edge.
  - 3 BOTH (R/W): 1 = both edges, overrides POL.
  - 4 ID (R only): bit7 = irq_any, bits2:0 = irq_id, others 0. Writes ignored.
  - 5 SWSET (write-1-to-set PEND, reads 0).
- Addresses outside the decoded range read 8'h00 and ignore writes.
- io_rdata is combinational from io_add and current register state.
- Writes take effect on the CLK rising edge where io_we=1.
- Edge detection:
  - s = last synchroniser stage; p = s delayed one clock.
  - rise = s & ~p; fall = ~s & p.
  - evt = BOTH ? (rise|fall) : (POL ? fall : rise).
- Priming:
  - A 3-bit counter increments from reset until it reaches SYNC_STAGES+1, then holds.
  - evt is forced to 0 while the counter is below SYNC_STAGES+1. Consequence: an input already high (or low with POL=1) at reset release produces no spurious event.
- Latency: an EINT transition setup-met before edge k sets PEND at edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 rising edges including k. irq follows PEND combinationally.
- PEND update per bit:
  - next = (PEND & ~clr) | evt | sw.
  - clr = W1C write to offset 1; sw = write to offset 5.
  - Set beats clear in the same cycle, so no event is lost.
- PEND latches regardless of EN. Enabling a channel with PEND already set raises irq on the next cycle after the EN write.
- Repeated events while PEND=1 are absorbed; there is no counting.
- Priority: lowest index wins. irq_id is a combinational priority encode of irq.
- Pulses shorter than one CLK period may be missed. Guaranteed detection requires input high and low phases of at least 2 CLK periods each.
- Changing POL/BOTH takes effect for evt on the cycle after the write. Changing them does not itself create an event.
- NRST assertion mid-operation clears everything immediately, including priming. Events are suppressed again for SYNC_STAGES+1 cycles after release.

Test Plan:
1. Reset/priming: hold EINT=3'b111 through NRST release, SYNC_STAGES=2, N_CH=3 -> PEND stays 0 for 20 cycles; irq=0; read offset 4 = 8'h00.
2. Rising latency: EN=8'h07; raise EINT[1] before edge k -> PEND=3'b010 and irq[1]=1 at edge k+2 (not before); offset 4 reads 8'h81; irq_id=1.
3. Polarity/both: POL=3'b001, BOTH=3'b100; pulse EINT[0] high for 4 cycles -> PEND[0] set only after the falling transition. Pulse EINT[2] -> PEND[2] set after the rise, and again re-set after the fall if cleared between the two transitions.
4. Priority/mask: PEND=3'b110 via SWSET write 8'h06, EN=8'h04 -> irq=3'b100, irq_id=2. Then EN=8'h07 -> irq_id=1. W1C write 8'h02 to offset 1 -> irq_id=2.
5. Set-wins: W1C 8'h01 in the same cycle that a detected EINT[0] event occurs -> PEND[0] remains 1. Then W1C alone -> PEND[0]=0.
6. Decode/width: N_CH=2, ADD_BASE=8'h10; write 8'hFF to 8'h10 -> reads 8'h03. Write to 8'h16 -> ignored; read of 8'h16 = 8'h00. Write to 8'h14 -> ID unchanged. Assert NRST mid-pending -> all outputs 0 asynchronously.
